// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared FSM state type and sizing constants for the PISO serializer
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - frame bit counter, 0..WIDTH-1, with last-bit flag
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // start wins over enable so a back-to-back frame restarts at zero
    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer; PISO_SERIALIZER_PARITY_EN appends an even-parity bit
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done
);

    localparam int CNT_W = cnt_width(WIDTH);
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int DONE_AT = WIDTH - 1;
`else
    localparam int DONE_AT = WIDTH - 2;
`endif

    piso_state_e      state_q;
    logic [WIDTH-1:0] sreg_q;
    logic             serial_out_q;
    logic             serial_valid_q;
    logic             frame_done_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             parity_q;
`endif

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             cnt_en;
    logic             accept;
    logic             in_head;
    logic             sreg_head;
    logic [WIDTH-1:0] in_rest;
    logic [WIDTH-1:0] sreg_rest;

    // frame_done_q marks the final bit cycle, which is also the back-to-back load slot
    assign load_ready = !clear && ((state_q == IDLE) || frame_done_q);
    assign accept     = load_valid && load_ready;
    assign cnt_en     = (state_q == SHIFT) && !cnt_last;

    assign in_head   = MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
    assign in_rest   = MSB_FIRST ? (parallel_in << 1) : (parallel_in >> 1);
    assign sreg_head = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sreg_rest = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

    piso_bit_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .clear (clear),
        .start (accept),
        .enable(cnt_en),
        .count (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q        <= IDLE;
            sreg_q         <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            if (accept) begin
                // first bit goes out on the accepting edge; the rest wait in sreg_q
                state_q        <= SHIFT;
                sreg_q         <= in_rest;
                serial_out_q   <= in_head;
                serial_valid_q <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
                parity_q       <= ^parallel_in;
`endif
            end else begin
                case (state_q)
                    SHIFT: begin
                        frame_done_q <= (cnt == CNT_W'(DONE_AT));
                        if (!cnt_last) begin
                            sreg_q       <= sreg_rest;
                            serial_out_q <= sreg_head;
                        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                            state_q      <= PARITY;
                            serial_out_q <= parity_q;
`else
                            state_q        <= IDLE;
                            serial_out_q   <= 1'b0;
                            serial_valid_q <= 1'b0;
`endif
                        end
                    end
`ifdef PISO_SERIALIZER_PARITY_EN
                    PARITY: begin
                        state_q        <= IDLE;
                        serial_out_q   <= 1'b0;
                        serial_valid_q <= 1'b0;
                    end
`endif
                    default: begin
                        state_q        <= IDLE;
                        serial_out_q   <= 1'b0;
                        serial_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign frame_done   = frame_done_q;

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, matching a left-shift SIPO receiver; 0 sends bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clear  input  1  reset, synchronous and active-high.
REQ-005 load_valid  input  1  parallel_in holds a word to send.
REQ-006 parallel_in  input  WIDTH  word to serialize; sampled only on an accepted load.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 serial_out  output  1  current serial bit, registered.
REQ-009 serial_valid  output  1  serial_out carries a frame bit this cycle, registered.
REQ-010 frame_done  output  1  high during the final bit cycle of a frame, registered.

Function
REQ-011 FSM states SHALL be IDLE and SHIFT, plus PARITY when the parity feature is compiled in.
REQ-012 A load SHALL be accepted on the posedge where load_valid and load_ready are both 1; parallel_in is copied into the internal shift register at that edge.
REQ-013 In every cycle where load_ready is 0, load_valid SHALL be ignored and no state change caused by it.
REQ-014 Latency: for a load accepted at edge N, data bits SHALL appear on serial_out with serial_valid=1 in the WIDTH cycles following edges N..N+WIDTH-1, in the order set by MSB_FIRST.
REQ-015 A bit counter SHALL count 0..WIDTH-1 in SHIFT; at count WIDTH-1 the FSM leaves SHIFT (to PARITY if enabled, else to IDLE or to a new SHIFT frame).
REQ-016 load_ready SHALL be 1 in IDLE and in the final bit cycle of a frame, and 0 otherwise and whenever clear is 1.
REQ-017 A load accepted in the final bit cycle SHALL start the next frame with zero idle cycles between frames.
REQ-018 frame_done SHALL be 1 for exactly one cycle per completed frame, coincident with its last serial bit.
REQ-019 Outside frames, serial_out and serial_valid SHALL be 0.

Reset
REQ-020 While clear is 1 at a posedge: state becomes IDLE; counter, shift register, serial_out, serial_valid and frame_done become 0.
REQ-021 Clear mid-frame SHALL abort the frame: no frame_done; serial_valid is 0 from the next cycle; load_ready is 1 in the first cycle after clear deasserts.

Configuration
REQ-022 Macro PISO_SERIALIZER_PARITY_EN: when defined, each frame SHALL append one even-parity bit (XOR of all WIDTH data bits) in state PARITY with serial_valid=1; frame length is WIDTH+1; frame_done and the back-to-back load_ready move to the parity cycle.
REQ-023 When the macro is not defined, the PARITY state and parity logic SHALL be absent and the frame length is WIDTH.

Structure
REQ-024 Package piso_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PARITY) and the constants for default width and counter width, computed with $clog2.
REQ-025 The bit counter SHALL be the sub-module piso_bit_counter, with inputs clk, clear, start and enable, and outputs count and last.

Verification (WIDTH=4, MSB_FIRST=1 unless stated)
REQ-026 Load 4'b1011 from IDLE -> serial_out 1,0,1,1 in the next 4 cycles with serial_valid=1; frame_done only on the 4th bit cycle.
REQ-027 Loop serial_out into a 4-bit left-shift SIPO clocked on clk, then load 4'b1011 -> SIPO parallel_out = 4'b1011 in the cycle after frame_done.
REQ-028 Load 4'b1011, then hold load_valid with 4'b0100 -> second word accepted on the last bit cycle; output stream is 1,0,1,1,0,1,0,0 with no gap; two frame_done pulses.
REQ-029 Assert clear during the 2nd bit of 4'b1110 -> serial_valid 0 next cycle, no frame_done, load_ready=1 in the first cycle after clear drops.
REQ-030 Hold load_valid with 4'b0110 during a busy frame -> word not accepted and stream unchanged until load_ready=1.
REQ-031 With PISO_SERIALIZER_PARITY_EN, load 4'b1011 -> stream 1,0,1,1,1 (5 cycles); frame_done on the parity cycle. With MSB_FIRST=0, the same load gives 1,1,0,1,1.
